// File: rtl/modulo_conversor_bcd.sv
// modulo_conversor_bcd: sequential binary-to-BCD converter using shift-add-3 (double dabble).
// It converts one input bit per clock and uses a start/done handshake.
// The result is held until the next conversion completes.
// Optional feature macro: MODULO_CONVERSOR_BCD_SEG7_EN adds the active-low 7-segment output seg_out.
module modulo_conversor_bcd #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    bin_sr;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_adj;
  logic                ovf_acc;
  logic [CW-1:0]       cnt;

`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
  // Active-low segment pattern, bit0=a .. bit6=g; non-decimal codes blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
`endif

  // Add-3 correction of every accumulator digit that is 5 or more, ahead of the shift
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Control FSM with registered handshake outputs and the shift datapath.
  // DONE lasts one cycle. Its exit edge loads the result, raises done and
  // reasserts ready together. A start held high is therefore accepted every
  // WIDTH+2 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      bin_sr   <= '0;
      acc      <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
      seg_out  <= '1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(WIDTH);
            state   <= SHIFT;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          acc     <= {acc_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
          bin_sr  <= bin_sr << 1;
          ovf_acc <= ovf_acc | acc_adj[4*DIGITS-1];
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bcd_out  <= acc;
          overflow <= ovf_acc;
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
          for (int unsigned i = 0; i < DIGITS; i++) begin
            seg_out[7*i +: 7] <= seg7(acc[4*i +: 4]);
          end
`endif
          done  <= 1'b1;
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_conversor_bcd.sv
// Scoreboard bench for modulo_conversor_bcd, exercising four parameter sets.
module tb_modulo_conversor_bcd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A: WIDTH=7 DIGITS=3
  logic a_start = 1'b0;
  logic [6:0] a_bin = '0;
  logic a_ready, a_busy, a_done, a_ovf;
  logic [11:0] a_bcd;
  // B: WIDTH=7 DIGITS=2
  logic b_start = 1'b0;
  logic [6:0] b_bin = '0;
  logic b_ready, b_busy, b_done, b_ovf;
  logic [7:0] b_bcd;
  // C: WIDTH=16 DIGITS=5
  logic c_start = 1'b0;
  logic [15:0] c_bin = '0;
  logic c_ready, c_busy, c_done, c_ovf;
  logic [19:0] c_bcd;
  // D: WIDTH=1 DIGITS=1
  logic d_start = 1'b0;
  logic [0:0] d_bin = '0;
  logic d_ready, d_busy, d_done, d_ovf;
  logic [3:0] d_bcd;
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
  logic [20:0] a_seg;
  logic [13:0] b_seg;
  logic [34:0] c_seg;
  logic [6:0]  d_seg;
`endif

  modulo_conversor_bcd #(.WIDTH(7), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .bin_in(a_bin), .ready(a_ready),
    .busy(a_busy), .done(a_done), .bcd_out(a_bcd), .overflow(a_ovf)
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
    , .seg_out(a_seg)
`endif
  );
  modulo_conversor_bcd #(.WIDTH(7), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .bin_in(b_bin), .ready(b_ready),
    .busy(b_busy), .done(b_done), .bcd_out(b_bcd), .overflow(b_ovf)
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
    , .seg_out(b_seg)
`endif
  );
  modulo_conversor_bcd #(.WIDTH(16), .DIGITS(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .bin_in(c_bin), .ready(c_ready),
    .busy(c_busy), .done(c_done), .bcd_out(c_bcd), .overflow(c_ovf)
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
    , .seg_out(c_seg)
`endif
  );
  modulo_conversor_bcd #(.WIDTH(1), .DIGITS(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .bin_in(d_bin), .ready(d_ready),
    .busy(d_busy), .done(d_done), .bcd_out(d_bcd), .overflow(d_ovf)
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
    , .seg_out(d_seg)
`endif
  );

  // Expected {bcd, overflow} per instance
  logic [12:0] qa[$];
  logic [8:0]  qb[$];
  logic [20:0] qc[$];
  logic [4:0]  qd[$];
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
  logic [6:0]  qc_seg[$];
`endif
  int a_dones = 0, a_last = 0, a_prev = 0;
  int b_dones = 0, c_dones = 0, d_dones = 0, d_last = 0;

  // Monitors: pop and compare on every done pulse
  always @(negedge clk) begin
    if (a_done) begin
      a_prev = a_last;
      a_last = cyc;
      a_dones++;
      if (qa.size() == 0) chk("a_unexpected_done", {19'b0, a_bcd, a_ovf}, 32'hFFFF_FFFF);
      else chk("a_result", {19'b0, a_bcd, a_ovf}, {19'b0, qa.pop_front()});
    end
    if (b_done) begin
      b_dones++;
      if (qb.size() == 0) chk("b_unexpected_done", {23'b0, b_bcd, b_ovf}, 32'hFFFF_FFFF);
      else chk("b_result", {23'b0, b_bcd, b_ovf}, {23'b0, qb.pop_front()});
    end
    if (c_done) begin
      c_dones++;
      if (qc.size() == 0) chk("c_unexpected_done", {11'b0, c_bcd, c_ovf}, 32'hFFFF_FFFF);
      else chk("c_result", {11'b0, c_bcd, c_ovf}, {11'b0, qc.pop_front()});
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
      if (qc_seg.size() != 0) chk("c_seg_digit0", {25'b0, c_seg[6:0]}, {25'b0, qc_seg.pop_front()});
`endif
    end
    if (d_done) begin
      d_dones++;
      d_last = cyc;
      if (qd.size() == 0) chk("d_unexpected_done", {27'b0, d_bcd, d_ovf}, 32'hFFFF_FFFF);
      else chk("d_result", {27'b0, d_bcd, d_ovf}, {27'b0, qd.pop_front()});
    end
  end

  function automatic int cnt_of(input int which);
    case (which)
      0: cnt_of = a_dones;
      1: cnt_of = b_dones;
      2: cnt_of = c_dones;
      default: cnt_of = d_dones;
    endcase
  endfunction

  // Bounded wait until the selected done counter reaches target
  task automatic wait_done(input int which, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cnt_of(which) >= target) return;
      @(negedge clk);
      #1;
    end
    if (cnt_of(which) < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done_timeout: instance %0d got %0d dones, expected %0d", which, cnt_of(which), target);
    end
  endtask

  int k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", a_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_bcd", a_bcd, 0);
    chk("rst_ovf", a_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 99 with latency check
    a_bin = 7'd99; a_start = 1'b1; qa.push_back({12'h099, 1'b0});
    @(negedge clk); k = cyc; a_start = 1'b0;
    #1;
    chk("a_busy_shift", a_busy, 1);
    chk("a_ready_shift", a_ready, 0);
    wait_done(0, 1, 30);
    chk("a_latency", a_last - k, 8);

    // 0 then 127 back-to-back with start held
    @(negedge clk);
    a_bin = 7'd0; a_start = 1'b1;
    qa.push_back({12'h000, 1'b0}); qa.push_back({12'h127, 1'b0});
    @(negedge clk); k = cyc; a_bin = 7'd127;
    repeat (9) @(negedge clk);
    a_start = 1'b0;
    wait_done(0, 3, 40);
    chk("a_b2b_first_latency", a_prev - k, 8);
    chk("a_b2b_spacing", a_last - a_prev, 9);

    // 45, with an ignored start mid-SHIFT carrying 12
    @(negedge clk);
    a_bin = 7'd45; a_start = 1'b1; qa.push_back({12'h045, 1'b0});
    @(negedge clk); a_start = 1'b0;
    repeat (3) @(negedge clk);
    a_bin = 7'd12; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    #1;
    chk("a_hold_prev", a_bcd, 12'h127);
    wait_done(0, 4, 30);
    repeat (12) @(negedge clk);
    #1;
    chk("a_single_done", a_dones, 4);

    // Reset mid-SHIFT aborts without done
    a_bin = 7'd100; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", a_bcd, 0);
    chk("abort_ovf", a_ovf, 0);
    chk("abort_ready", a_ready, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("abort_no_done", a_dones, 4);

    // DIGITS=2 truncation and overflow
    b_bin = 7'd127; b_start = 1'b1; qb.push_back({8'h27, 1'b1});
    @(negedge clk); b_start = 1'b0;
    wait_done(1, 1, 30);
    @(negedge clk);
    b_bin = 7'd99; b_start = 1'b1; qb.push_back({8'h99, 1'b0});
    @(negedge clk); b_start = 1'b0;
    wait_done(1, 2, 30);
    @(negedge clk);
    b_bin = 7'd100; b_start = 1'b1; qb.push_back({8'h00, 1'b1});
    @(negedge clk); b_start = 1'b0;
    wait_done(1, 3, 30);

    // WIDTH=16 DIGITS=5 full range
    @(negedge clk);
    c_bin = 16'd65535; c_start = 1'b1; qc.push_back({20'h65535, 1'b0});
`ifdef MODULO_CONVERSOR_BCD_SEG7_EN
    qc_seg.push_back(7'b0010010);
`endif
    @(negedge clk); c_start = 1'b0;
    wait_done(2, 1, 40);

    // WIDTH=1 DIGITS=1: single shift edge
    @(negedge clk);
    d_bin = 1'b1; d_start = 1'b1; qd.push_back({4'h1, 1'b0});
    @(negedge clk); k = cyc; d_start = 1'b0;
    wait_done(3, 1, 20);
    chk("d_latency", d_last - k, 2);
    @(negedge clk);
    d_bin = 1'b0; d_start = 1'b1; qd.push_back({4'h0, 1'b0});
    @(negedge clk); d_start = 1'b0;
    wait_done(3, 2, 20);

    repeat (3) @(negedge clk);
    chk("queues_empty", qa.size() + qb.size() + qc.size() + qd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
